otbn_pq_ntt_seq: RTL and testbench
==================================

Name: otbn_pq_ntt_seq

Overview:
- Address/twiddle sequencer for the PQ butterfly datapath.
- On a start command it walks every stage, group and butterfly of an in-place NTT (Cooley-Tukey, CT) or inverse NTT (Gentleman-Sande, GS) of size N = 2^LogN.
- For each butterfly it emits the two coefficient indices, the twiddle-table index and the butterfly op over a valid/ready handshake.
- It replaces the software m/j2/j/idx0/idx1 bookkeeping ahead of AluOpPqButterflyCT / AluOpPqButterflyGS issue.

Parameters:
- LogN, 8, log2 of transform size N; legal range 2..12.
- StW, $clog2(LogN), width of the stage counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  start pulse; accepted only in IDLE
- mode_i  in  1  sampled on an accepted start: 0 = forward CT, 1 = inverse GS
- abort_i  in  1  terminate the current sequence
- busy_o  out  1  high from the cycle after an accepted start through the DONE cycle
- done_o  out  1  one-cycle pulse after the final butterfly handshake
- bf_valid_o  out  1  butterfly descriptor valid
- bf_ready_i  in  1  datapath accepts the descriptor
- bf_idx0_o  out  LogN  first coefficient index
- bf_idx1_o  out  LogN  second coefficient index
- bf_tw_idx_o  out  LogN  twiddle-table index, range 1..N-1
- bf_op_o  out  1  0 = CT butterfly, 1 = GS butterfly; equals the latched mode
- bf_last_o  out  1  high with the final descriptor of the transform
- stage_o  out  StW  current stage s

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- FSM states:
  - IDLE: on start_i, latch mode_i, clear s/g/k, go to ISSUE.
  - ISSUE: bf_valid_o is high.
  - DONE: done_o is high for one cycle, then return to IDLE.
- Forward (CT), stage s = 0..LogN-1:
  - half = N>>(s+1); groups = 1<<s.
  - Group g = 0..groups-1: tw = groups+g.
  - Butterfly k = 0..half-1: idx0 = 2*half*g + k, idx1 = idx0 + half.
- Inverse (GS), stage s = 0..LogN-1:
  - half = 1<<s; groups = N>>(s+1).
  - tw = 2*groups-1-g.
  - idx0 and idx1 use the same formula as forward.
- Loop order: k fastest, then g, then s. Each pass issues N/2 butterflies; the total is LogN*N/2.
- Handshake:
  - A transfer occurs when bf_valid_o && bf_ready_i.
  - All bf_* outputs and stage_o stay stable while valid is high and ready is low.
  - The next descriptor appears the cycle after a transfer. Sustained throughput is one butterfly per cycle.
- Latency: start accepted in cycle t gives the first descriptor valid at t+1. The last transfer at cycle u gives done_o at u+1 and IDLE at u+2.
- Last descriptor: bf_last_o is high only on the descriptor with s = LogN-1, g = groups-1, k = half-1.
- Start handling: start_i in ISSUE or DONE is ignored and the latched mode is unchanged.
- Abort: abort_i in ISSUE forces IDLE next cycle. bf_valid_o drops, there is no done_o, and counters clear. An abort in the same cycle as a transfer still aborts; that transfer counts as accepted by the datapath. abort_i in IDLE or DONE has no effect.
- Start and abort together in IDLE: start wins.
- rst_i at any time: next cycle matches the reset state; any in-flight sequence is discarded.
- Arithmetic: all index math is unsigned LogN bits and never overflows given the loop bounds. tw never reaches 0 or N.
- Counter updates: incremental only (shift and compare), no multipliers.
  - Keep a base register of 2*half*g and add half per group.
  - half updates by shift per stage: right for CT, left for GS.

Test Plan:
- Forward CT, LogN=3, bf_ready_i tied high. Start at t0 produces 12 descriptors on t1..t12 as (idx0,idx1,tw):
  - Stage 0: (0,4,1) (1,5,1) (2,6,1) (3,7,1).
  - Stage 1: (0,2,2) (1,3,2) (4,6,3) (5,7,3).
  - Stage 2: (0,1,4) (2,3,5) (4,5,6) (6,7,7).
  - bf_last_o at t12, done_o at t13, busy_o low at t14.
- Inverse GS, LogN=3:
  - Stage 0: (0,1,7) (2,3,6) (4,5,5) (6,7,4).
  - Stage 1: (0,2,3) (1,3,3) (4,6,2) (5,7,2).
  - Stage 2: (0,4,1) (1,5,1) (2,6,1) (3,7,1).
  - bf_op_o = 1 throughout.
- Backpressure: random bf_ready_i at 30% duty, LogN=8.
  - Descriptors are stable while stalled, there are exactly 1024 transfers and none are duplicated or skipped.
  - done_o fires once, one cycle after the final transfer.
- Abort after the 5th transfer in forward LogN=3 gives bf_valid_o=0 next cycle and no done_o. A new start then begins again at (0,4,1).
- start_i pulsed mid-sequence with mode_i flipped: the sequence and bf_op_o are unchanged. rst_i asserted mid-sequence: all outputs 0 next cycle.
- LogN=8 forward, ready high:
  - The first tw of stage 7 is 128 and the final descriptor is (254,255,255).
  - Checksum of all tw equals a reference model.

Source files
------------

// File: rtl/otbn_pq_ntt_seq.sv
// Address/twiddle sequencer for the PQ butterfly datapath: walks every stage,
// group and butterfly of an in-place CT NTT or GS inverse NTT of size 2^LogN.
module otbn_pq_ntt_seq #(
    parameter int unsigned LogN = 8,
    parameter int unsigned StW  = $clog2(LogN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            mode_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            bf_valid_o,
    input  logic            bf_ready_i,
    output logic [LogN-1:0] bf_idx0_o,
    output logic [LogN-1:0] bf_idx1_o,
    output logic [LogN-1:0] bf_tw_idx_o,
    output logic            bf_op_o,
    output logic            bf_last_o,
    output logic [StW-1:0]  stage_o
);

    localparam int unsigned N = 1 << LogN;
    localparam logic [LogN-1:0] One       = LogN'(1);
    localparam logic [LogN-1:0] HalfInit  = LogN'(N / 2);
    localparam logic [LogN-1:0] TwInvInit = LogN'(N - 1);
    localparam logic [StW-1:0]  StLast    = StW'(LogN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDone
    } state_e;

    state_e          state;
    logic [LogN-1:0] k, g, half, groups, base;

    logic [LogN-1:0] k_n, g_n, half_n, groups_n, base_n;
    logic [LogN-1:0] idx0_n, idx1_n, tw_n;
    logic [StW-1:0]  s_n;
    logic            last_n;
    logic            seq_end;

    // Next descriptor: k fastest, then g, then stage; stage-local values by shift only.
    always_comb begin
        k_n      = k;
        g_n      = g;
        s_n      = stage_o;
        half_n   = half;
        groups_n = groups;
        base_n   = base;
        idx0_n   = bf_idx0_o;
        idx1_n   = bf_idx1_o;
        tw_n     = bf_tw_idx_o;
        seq_end  = 1'b0;
        if (k != half - One) begin
            k_n    = k + One;
            idx0_n = bf_idx0_o + One;
            idx1_n = bf_idx1_o + One;
        end else if (g != groups - One) begin
            k_n    = '0;
            g_n    = g + One;
            base_n = base + (half << 1);
            idx0_n = base_n;
            idx1_n = base_n + half;
            tw_n   = bf_op_o ? bf_tw_idx_o - One : bf_tw_idx_o + One;
        end else if (stage_o != StLast) begin
            s_n      = stage_o + StW'(1);
            half_n   = bf_op_o ? half << 1 : half >> 1;
            groups_n = bf_op_o ? groups >> 1 : groups << 1;
            k_n      = '0;
            g_n      = '0;
            base_n   = '0;
            idx0_n   = '0;
            idx1_n   = half_n;
            tw_n     = bf_op_o ? (groups_n << 1) - One : groups_n;
        end else begin
            seq_end = 1'b1;
        end
        last_n = (s_n == StLast) && (g_n == groups_n - One) && (k_n == half_n - One);
    end

    // Reset, abort and the DONE cycle all return everything to the idle state.
    always_ff @(posedge clk_i) begin
        if (rst_i || state == StDone || (state == StIssue && abort_i)) begin
            state       <= StIdle;
            k           <= '0;
            g           <= '0;
            half        <= '0;
            groups      <= '0;
            base        <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            bf_valid_o  <= 1'b0;
            bf_idx0_o   <= '0;
            bf_idx1_o   <= '0;
            bf_tw_idx_o <= '0;
            bf_op_o     <= 1'b0;
            bf_last_o   <= 1'b0;
            stage_o     <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start_i) begin
                        state       <= StIssue;
                        k           <= '0;
                        g           <= '0;
                        base        <= '0;
                        half        <= mode_i ? One : HalfInit;
                        groups      <= mode_i ? HalfInit : One;
                        busy_o      <= 1'b1;
                        bf_valid_o  <= 1'b1;
                        bf_idx0_o   <= '0;
                        bf_idx1_o   <= mode_i ? One : HalfInit;
                        bf_tw_idx_o <= mode_i ? TwInvInit : One;
                        bf_op_o     <= mode_i;
                        bf_last_o   <= 1'b0;
                        stage_o     <= '0;
                    end
                end
                StIssue: begin
                    if (bf_valid_o && bf_ready_i) begin
                        if (seq_end) begin
                            state      <= StDone;
                            bf_valid_o <= 1'b0;
                            bf_last_o  <= 1'b0;
                            done_o     <= 1'b1;
                        end else begin
                            k           <= k_n;
                            g           <= g_n;
                            half        <= half_n;
                            groups      <= groups_n;
                            base        <= base_n;
                            bf_idx0_o   <= idx0_n;
                            bf_idx1_o   <= idx1_n;
                            bf_tw_idx_o <= tw_n;
                            bf_last_o   <= last_n;
                            stage_o     <= s_n;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_otbn_pq_ntt_seq.sv
// Scoreboard bench for otbn_pq_ntt_seq: a LogN=3 instance (index 0) and a LogN=8 instance (index 1).
module tb_otbn_pq_ntt_seq;

    logic clk = 1'b0;
    logic rst;
    logic start [2];
    logic mode  [2];
    logic abort [2];
    logic ready [2];
    logic o_busy [2];
    logic o_done [2];
    logic o_valid [2];
    logic o_op [2];
    logic o_last [2];
    logic [2:0] d3_i0, d3_i1, d3_tw;
    logic [1:0] d3_st;
    logic [7:0] d8_i0, d8_i1, d8_tw;
    logic [2:0] d8_st;

    int total = 0;
    int bad   = 0;

    // Descriptor packing: {op, last, stage[3:0], idx0[11:0], idx1[11:0], tw[11:0]}
    logic [41:0] exp_q [$];
    logic [41:0] obs_q [$];
    int          m_twsum;
    int          r_nx, r_twsum, r_tw7, r_lcyc;
    logic [41:0] r_lastd;

    int fwd_tbl [12][3] = '{'{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1},
                            '{0,2,2}, '{1,3,2}, '{4,6,3}, '{5,7,3},
                            '{0,1,4}, '{2,3,5}, '{4,5,6}, '{6,7,7}};

    always #5 clk = ~clk;

    otbn_pq_ntt_seq #(.LogN(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .mode_i(mode[0]), .abort_i(abort[0]),
        .busy_o(o_busy[0]), .done_o(o_done[0]), .bf_valid_o(o_valid[0]), .bf_ready_i(ready[0]),
        .bf_idx0_o(d3_i0), .bf_idx1_o(d3_i1), .bf_tw_idx_o(d3_tw), .bf_op_o(o_op[0]),
        .bf_last_o(o_last[0]), .stage_o(d3_st)
    );

    otbn_pq_ntt_seq #(.LogN(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .mode_i(mode[1]), .abort_i(abort[1]),
        .busy_o(o_busy[1]), .done_o(o_done[1]), .bf_valid_o(o_valid[1]), .bf_ready_i(ready[1]),
        .bf_idx0_o(d8_i0), .bf_idx1_o(d8_i1), .bf_tw_idx_o(d8_tw), .bf_op_o(o_op[1]),
        .bf_last_o(o_last[1]), .stage_o(d8_st)
    );

    function automatic logic [41:0] obs(input int sel);
        if (sel == 0)
            return {o_op[0], o_last[0], 4'(d3_st), 12'(d3_i0), 12'(d3_i1), 12'(d3_tw)};
        return {o_op[1], o_last[1], 4'(d8_st), 12'(d8_i0), 12'(d8_i1), 12'(d8_tw)};
    endfunction

    // Reference descriptor list straight from the loop formulas.
    task automatic push_model(input int lg, input bit md);
        int n = 1 << lg;
        int half, groups, i0, tw;
        bit lst;
        m_twsum = 0;
        for (int s = 0; s < lg; s++) begin
            half   = md ? (1 << s) : (n >> (s + 1));
            groups = md ? (n >> (s + 1)) : (1 << s);
            for (int g = 0; g < groups; g++) begin
                for (int k = 0; k < half; k++) begin
                    i0  = 2 * half * g + k;
                    tw  = md ? (2 * groups - 1 - g) : (groups + g);
                    lst = (s == lg - 1) && (g == groups - 1) && (k == half - 1);
                    m_twsum += tw;
                    exp_q.push_back({md, lst, 4'(s), 12'(i0), 12'(i0 + half), 12'(tw)});
                end
            end
        end
    endtask

    task automatic run_seq(input int sel, input bit md, input int duty,
                           input int abort_after, input int flip_after);
        int lg = (sel != 0) ? 8 : 3;
        int cyc = 0;
        bit fin = 0, stall = 0, ab = 0, seen_done;
        logic [41:0] prevd, cur, e;
        exp_q.delete();
        obs_q.delete();
        push_model(lg, md);
        r_nx = 0; r_twsum = 0; r_tw7 = -1; r_lcyc = -1; r_lastd = '0; prevd = '0;
        @(posedge clk); #1;
        start[sel] = 1'b1; mode[sel] = md; ready[sel] = 1'b0; abort[sel] = 1'b0;
        @(posedge clk); #1;
        start[sel] = 1'b0;
        forever begin
            ready[sel] = (duty >= 100) || ($urandom_range(99) < duty);
            abort[sel] = 1'b0;
            start[sel] = 1'b0;
            if (!fin && !ab && r_nx == abort_after) begin
                abort[sel] = 1'b1;
                ready[sel] = 1'b0;
            end
            if (!fin && r_nx == flip_after) begin
                start[sel] = 1'b1;
                mode[sel]  = ~md;
            end
            @(negedge clk);
            cur = obs(sel);
            if (fin) begin
                total++;
                if (o_done[sel] !== 1'b1 || o_busy[sel] !== 1'b1 || o_valid[sel] !== 1'b0)
                    begin bad++; $display("FAIL done_pulse: done=%b busy=%b valid=%b required 1 1 0",
                                          o_done[sel], o_busy[sel], o_valid[sel]); end
                @(posedge clk); #1; ready[sel] = 1'b0;
                @(negedge clk);
                total++;
                if (o_done[sel] !== 1'b0 || o_busy[sel] !== 1'b0)
                    begin bad++; $display("FAIL idle_after_done: done=%b busy=%b required 0 0",
                                          o_done[sel], o_busy[sel]); end
                break;
            end
            if (ab) begin
                total++;
                if (o_valid[sel] !== 1'b0 || o_busy[sel] !== 1'b0)
                    begin bad++; $display("FAIL abort_drop: valid=%b busy=%b required 0 0",
                                          o_valid[sel], o_busy[sel]); end
                seen_done = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (o_done[sel] !== 1'b0) seen_done = 1;
                end
                total++;
                if (seen_done) begin bad++; $display("FAIL abort_no_done: done seen=1 required 0"); end
                break;
            end
            total++;
            if (o_done[sel] !== 1'b0) begin bad++; $display("FAIL early_done: done=%b required 0", o_done[sel]); end
            if (cyc == 0) begin
                total++;
                if (o_valid[sel] !== 1'b1 || o_busy[sel] !== 1'b1)
                    begin bad++; $display("FAIL first_latency: valid=%b busy=%b required 1 1",
                                          o_valid[sel], o_busy[sel]); end
            end
            if (o_valid[sel] === 1'b1) begin
                if (stall) begin
                    total++;
                    if (cur !== prevd) begin bad++; $display("FAIL stall_stable: got %h required %h", cur, prevd); end
                end
                if (ready[sel]) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++; $display("FAIL extra_xfer: got %h required none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin bad++; $display("FAIL desc #%0d: got %h required %h", r_nx, cur, e); end
                    end
                    obs_q.push_back(cur);
                    r_nx++;
                    r_twsum += int'(cur[11:0]);
                    if (int'(cur[39:36]) == lg - 1 && r_tw7 < 0) r_tw7 = int'(cur[11:0]);
                    if (cur[40]) begin fin = 1; r_lastd = cur; r_lcyc = cyc; end
                    stall = 0;
                end else begin
                    stall = 1;
                end
            end else begin
                total++; bad++;
                $display("FAIL valid_low: valid=%b required 1 at xfer %0d", o_valid[sel], r_nx);
            end
            if (abort[sel]) ab = 1;
            prevd = cur;
            cyc++;
            if (cyc > 20000) begin
                total++; bad++;
                $display("FAIL timeout: xfers=%0d required completion", r_nx);
                break;
            end
            @(posedge clk); #1;
        end
        ready[sel] = 1'b0; abort[sel] = 1'b0; start[sel] = 1'b0;
        if (!ab) begin
            total++;
            if (exp_q.size() != 0) begin bad++; $display("FAIL skipped: left=%0d required 0", exp_q.size()); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; mode[i] = 1'b0; abort[i] = 1'b0; ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs(i) !== 42'd0 || o_valid[i] !== 1'b0 || o_busy[i] !== 1'b0 || o_done[i] !== 1'b0)
                begin bad++; $display("FAIL reset_state[%0d]: desc=%h v=%b b=%b d=%b required all 0",
                                      i, obs(i), o_valid[i], o_busy[i], o_done[i]); end
        end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_fwd3();
        logic [41:0] d;
        run_seq(0, 1'b0, 100, -1, -1);
        total++;
        if (r_nx != 12) begin bad++; $display("FAIL fwd3_count: got %0d required 12", r_nx); end
        total++;
        if (r_lcyc != 11) begin bad++; $display("FAIL fwd3_last_cycle: got t%0d required t12", r_lcyc + 1); end
        for (int i = 0; i < 12 && i < obs_q.size(); i++) begin
            d = obs_q[i];
            total++;
            if (int'(d[35:24]) != fwd_tbl[i][0] || int'(d[23:12]) != fwd_tbl[i][1] || int'(d[11:0]) != fwd_tbl[i][2])
                begin bad++; $display("FAIL fwd3_table[%0d]: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", i,
                      d[35:24], d[23:12], d[11:0], fwd_tbl[i][0], fwd_tbl[i][1], fwd_tbl[i][2]); end
        end
    endtask

    task automatic test_inv3();
        run_seq(0, 1'b1, 100, -1, -1);
        total++;
        if (r_nx != 12) begin bad++; $display("FAIL inv3_count: got %0d required 12", r_nx); end
        total++;
        if (obs_q.size() == 0 || obs_q[0] !== {1'b1, 1'b0, 4'd0, 12'd0, 12'd1, 12'd7})
            begin bad++; $display("FAIL inv3_first: got %h required (0,1,7) op=1", obs_q.size() ? obs_q[0] : '0); end
    endtask

    task automatic test_abort();
        run_seq(0, 1'b0, 100, 5, -1);
        total++;
        if (r_nx != 5) begin bad++; $display("FAIL abort_xfers: got %0d required 5", r_nx); end
        run_seq(0, 1'b0, 100, -1, -1);
        total++;
        if (obs_q.size() == 0 || obs_q[0] !== {1'b0, 1'b0, 4'd0, 12'd0, 12'd4, 12'd1})
            begin bad++; $display("FAIL restart_first: got %h required (0,4,1)", obs_q.size() ? obs_q[0] : '0); end
    endtask

    task automatic test_start_ignored();
        run_seq(0, 1'b0, 100, -1, 4);
        total++;
        if (r_nx != 12) begin bad++; $display("FAIL start_ignored_count: got %0d required 12", r_nx); end
    endtask

    task automatic test_reset_midseq();
        @(posedge clk); #1; start[0] = 1'b1; mode[0] = 1'b0; ready[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if (o_valid[0] !== 1'b1) begin bad++; $display("FAIL pre_reset_active: valid=%b required 1", o_valid[0]); end
        @(negedge clk);
        total++;
        if (obs(0) !== 42'd0 || o_valid[0] !== 1'b0 || o_busy[0] !== 1'b0 || o_done[0] !== 1'b0)
            begin bad++; $display("FAIL reset_midseq: desc=%h v=%b b=%b d=%b required all 0",
                                  obs(0), o_valid[0], o_busy[0], o_done[0]); end
        @(posedge clk); #1; rst = 1'b0; ready[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_seq(0, 1'b1, 100, -1, -1);
        run_seq(0, 1'b0, 100, -1, -1);
        total++;
        if (r_lastd !== {1'b0, 1'b1, 4'd2, 12'd6, 12'd7, 12'd7})
            begin bad++; $display("FAIL b2b_last: got %h required (6,7,7) last", r_lastd); end
    endtask

    task automatic test_fwd8();
        run_seq(1, 1'b0, 100, -1, -1);
        total++;
        if (r_nx != 1024) begin bad++; $display("FAIL fwd8_count: got %0d required 1024", r_nx); end
        total++;
        if (r_tw7 != 128) begin bad++; $display("FAIL fwd8_stage7_tw: got %0d required 128", r_tw7); end
        total++;
        if (r_lastd !== {1'b0, 1'b1, 4'd7, 12'd254, 12'd255, 12'd255})
            begin bad++; $display("FAIL fwd8_final: got %h required (254,255,255)", r_lastd); end
        total++;
        if (r_twsum != m_twsum) begin bad++; $display("FAIL fwd8_twsum: got %0d required %0d", r_twsum, m_twsum); end
    endtask

    task automatic test_backpressure();
        run_seq(1, 1'b0, 30, -1, -1);
        total++;
        if (r_nx != 1024) begin bad++; $display("FAIL bp_count: got %0d required 1024", r_nx); end
        run_seq(1, 1'b1, 30, -1, -1);
        total++;
        if (r_twsum != m_twsum) begin bad++; $display("FAIL bp_inv_twsum: got %0d required %0d", r_twsum, m_twsum); end
    endtask

    initial begin
        test_reset();
        test_fwd3();
        test_inv3();
        test_abort();
        test_start_ignored();
        test_reset_midseq();
        test_back_to_back();
        test_fwd8();
        test_backpressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
